// File: rtl/riscv_next_pkg.sv
// rtl/riscv_next_pkg.sv - shared types for the next-PC redirect arbiter
package riscv_next_pkg;

  localparam int REDIRECT_ADDR_MAX = 64;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_ID   = 2'd2,
    SRC_EX   = 2'd3
  } redirect_src_e;

  typedef struct packed {
    redirect_src_e                src;
    logic [REDIRECT_ADDR_MAX-1:0] addr;
  } redirect_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam redirect_t REDIRECT_NONE = '{src: SRC_NONE, addr: '0};

  // Source encoding doubles as priority, so a plain compare picks the winner.
  function automatic redirect_t pick_higher(input redirect_t cur, input redirect_t cand);
    return (cand.src > cur.src) ? cand : cur;
  endfunction

endpackage

// File: rtl/riscv_next_redirect_arbiter_if.sv
// rtl/riscv_next_redirect_arbiter_if.sv - redirect request/response bundle between predictors, arbiter and fetch
interface riscv_next_redirect_arbiter_if
  import riscv_next_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) ();

  logic                  i_ex_valid;
  logic [ADDR_WIDTH-1:0] i_ex_addr;
  logic                  i_id_valid;
  logic [ADDR_WIDTH-1:0] i_id_addr;
  logic                  i_if_valid;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  i_fetch_ready;

  logic                  o_redirect_valid;
  logic [ADDR_WIDTH-1:0] o_redirect_addr;
  redirect_src_e         o_redirect_src;
  logic                  o_flush_if;
  logic                  o_flush_id;

  // master: the arbiter side, slave: predictors and fetch
  modport master (
    input  i_ex_valid, i_ex_addr, i_id_valid, i_id_addr, i_if_valid, i_if_addr, i_fetch_ready,
    output o_redirect_valid, o_redirect_addr, o_redirect_src, o_flush_if, o_flush_id
  );

  modport slave (
    output i_ex_valid, i_ex_addr, i_id_valid, i_id_addr, i_if_valid, i_if_addr, i_fetch_ready,
    input  o_redirect_valid, o_redirect_addr, o_redirect_src, o_flush_if, o_flush_id
  );

endinterface

// File: rtl/riscv_next_sat_counter.sv
// rtl/riscv_next_sat_counter.sv - saturating event counter with synchronous clear
module riscv_next_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             enable,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (enable) begin
      if (clear) begin
        count <= '0;
      end else if (inc && !(&count)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_next_redirect_arbiter.sv
// rtl/riscv_next_redirect_arbiter.sv - priority arbiter of EX/ID/IF next-PC redirects toward fetch
module riscv_next_redirect_arbiter
  import riscv_next_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          enable,
  input  logic                          i_cnt_clear,
  riscv_next_redirect_arbiter_if.master rif,
  output logic [CNT_WIDTH-1:0]          o_cnt_ex,
  output logic [CNT_WIDTH-1:0]          o_cnt_id,
  output logic [CNT_WIDTH-1:0]          o_cnt_if,
  output logic [CNT_WIDTH-1:0]          o_cnt_override
);

  arb_state_e state_q, state_d;
  redirect_t  hold_q, hold_d;
  redirect_t  req_ex, req_id, req_if;
  redirect_t  new_win, presented;
  logic       replace;
  logic       first_seen;
  logic       active;
  logic       accept;

  always_comb begin
    req_ex = REDIRECT_NONE;
    req_id = REDIRECT_NONE;
    req_if = REDIRECT_NONE;
    if (rif.i_ex_valid) begin
      req_ex.src                   = SRC_EX;
      req_ex.addr[ADDR_WIDTH-1:0] = rif.i_ex_addr;
    end
    if (rif.i_id_valid) begin
      req_id.src                   = SRC_ID;
      req_id.addr[ADDR_WIDTH-1:0] = rif.i_id_addr;
    end
    if (rif.i_if_valid) begin
      req_if.src                   = SRC_IF;
      req_if.addr[ADDR_WIDTH-1:0] = rif.i_if_addr;
    end
  end

  assign new_win = pick_higher(pick_higher(req_if, req_id), req_ex);

  // Only a strictly higher source may displace a held redirect.
  assign replace    = (state_q == ARB_HOLD) && (new_win.src > hold_q.src);
  assign presented  = ((state_q == ARB_IDLE) || replace) ? new_win : hold_q;
  assign first_seen = ((state_q == ARB_IDLE) && (new_win.src != SRC_NONE)) || replace;
  assign active     = enable && nreset;

  assign rif.o_redirect_valid = active && (presented.src != SRC_NONE);
  assign rif.o_redirect_addr  = nreset ? presented.addr[ADDR_WIDTH-1:0] : '0;
  assign rif.o_redirect_src   = nreset ? presented.src : SRC_NONE;
  assign rif.o_flush_if       = active && first_seen &&
                                ((presented.src == SRC_EX) || (presented.src == SRC_ID));
  assign rif.o_flush_id       = active && first_seen && (presented.src == SRC_EX);

  assign accept = rif.o_redirect_valid && rif.i_fetch_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (enable) begin
      case (state_q)
        ARB_IDLE: begin
          if ((new_win.src != SRC_NONE) && !rif.i_fetch_ready) begin
            state_d = ARB_HOLD;
            hold_d  = new_win;
          end
        end
        ARB_HOLD: begin
          if (rif.i_fetch_ready) begin
            state_d = ARB_IDLE;
            hold_d  = REDIRECT_NONE;
          end else if (replace) begin
            hold_d = new_win;
          end
        end
        default: begin
          state_d = ARB_IDLE;
          hold_d  = REDIRECT_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ARB_IDLE;
      hold_q  <= REDIRECT_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  riscv_next_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ex (
    .clk    (clk),
    .nreset (nreset),
    .enable (enable),
    .clear  (i_cnt_clear),
    .inc    (accept && (presented.src == SRC_EX)),
    .count  (o_cnt_ex)
  );

  riscv_next_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_id (
    .clk    (clk),
    .nreset (nreset),
    .enable (enable),
    .clear  (i_cnt_clear),
    .inc    (accept && (presented.src == SRC_ID)),
    .count  (o_cnt_id)
  );

  riscv_next_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_if (
    .clk    (clk),
    .nreset (nreset),
    .enable (enable),
    .clear  (i_cnt_clear),
    .inc    (accept && (presented.src == SRC_IF)),
    .count  (o_cnt_if)
  );

  riscv_next_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_override (
    .clk    (clk),
    .nreset (nreset),
    .enable (enable),
    .clear  (i_cnt_clear),
    .inc    (replace),
    .count  (o_cnt_override)
  );

endmodule

// File: doc/riscv_next_redirect_arbiter.md
Name: riscv_next_redirect_arbiter

Overview:
Arbitrates next-PC redirect requests from three strategy sources and presents one redirect to fetch. The sources are the EX branch/jump resolution, the ID early jump computation and the IF predictor. Holds a redirect while fetch is stalled, lets higher-priority requests override a held one, issues stage flushes, and keeps per-source saturating statistics counters. Sits between the jump-predictor strategies and the fetch PC mux.

Parameters:
ADDR_WIDTH, 64, redirect address width
CNT_WIDTH, 16, statistics counter width

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
enable  input  1  global advance enable; 0 freezes all state
i_ex_valid  input  1  EX redirect request (mispredict correction)
i_ex_addr  input  ADDR_WIDTH  EX redirect target
i_id_valid  input  1  ID redirect request (already gated by ID flush)
i_id_addr  input  ADDR_WIDTH  ID redirect target
i_if_valid  input  1  IF predictor redirect request
i_if_addr  input  ADDR_WIDTH  IF predictor target
i_fetch_ready  input  1  fetch accepts redirect this cycle
i_cnt_clear  input  1  synchronous clear of all counters
o_redirect_valid  output  1  redirect presented to fetch
o_redirect_addr  output  ADDR_WIDTH  redirect target
o_redirect_src  output  2  redirect_src_e of presented redirect
o_flush_if  output  1  kill IF stage contents
o_flush_id  output  1  kill ID stage contents
o_cnt_ex, o_cnt_id, o_cnt_if  output  CNT_WIDTH  accepted redirects per source
o_cnt_override  output  CNT_WIDTH  held redirects replaced by a higher-priority request

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on nreset.
- Priority: EX > ID > IF, encoded SRC_EX=3, SRC_ID=2, SRC_IF=1, SRC_NONE=0.
- States: IDLE, HOLD. Hold register holds {src, addr}.
- IDLE:
  - Winner is the highest-priority valid input, combinational, zero latency.
  - o_redirect_valid = any valid. o_redirect_addr and o_redirect_src come from the winner.
  - If i_fetch_ready: redirect is accepted, state stays IDLE.
  - Else: latch winner into hold, go to HOLD.
- HOLD:
  - Winner is chosen between the held entry and new inputs.
  - A new input replaces the held entry only if its priority is strictly higher. Equal or lower new inputs are dropped.
  - A replacement updates hold and increments o_cnt_override.
  - If i_fetch_ready: the presented redirect is accepted, go to IDLE, hold cleared.
- Accept = o_redirect_valid && i_fetch_ready. Increments the counter of o_redirect_src. Counters saturate at all-ones.
- Flushes: asserted combinationally only in the cycle a new winner first appears, i.e. an IDLE selection or a HOLD replacement. Not asserted while re-presenting an unchanged held entry.
  - SRC_EX: o_flush_if=1, o_flush_id=1.
  - SRC_ID: o_flush_if=1.
  - SRC_IF: no flush.
- i_cnt_clear: all counters go to 0 next cycle. Clear wins over a same-cycle increment.
- enable=0: state, hold and counters are frozen. o_redirect_valid, o_flush_if and o_flush_id are forced 0. Inputs that cycle are ignored, not latched.
- Reset (nreset low, async):
  - state=IDLE, hold={SRC_NONE,0}, all counters 0.
  - o_redirect_valid, o_flush_if, o_flush_id forced 0 while nreset is low.
  - o_redirect_addr=0, o_redirect_src=SRC_NONE.
  - Reset mid-HOLD discards the held redirect.
- Address width: addresses pass through unmodified, no arithmetic.

Decomposition:
- Shared package riscv_next_pkg holds:
  - redirect_src_e (2-bit enum SRC_NONE/IF/ID/EX)
  - redirect_t struct {src, addr}
  - arb_state_e {ARB_IDLE, ARB_HOLD}
- One sub-module, riscv_next_sat_counter: parameterised width, inc, clear, enable, async active-low reset. Instantiated four times.

Test Plan:
1. Reset, then i_if_valid=1, addr=0x1000, ready=1 -> same cycle: valid=1, addr=0x1000, src=IF, no flush. o_cnt_if=1 next cycle.
2. Same cycle i_ex (0x2000), i_id (0x3000), i_if (0x4000), ready=1 -> addr=0x2000, src=EX, flush_if=flush_id=1. Only o_cnt_ex increments.
3. i_id (0x3000) with ready=0 for 3 cycles, then ready=1 -> 0x3000 presented all 4 cycles, flush_if only in the first. o_cnt_id=1 after acceptance, state returns to IDLE.
4. In HOLD with ID 0x3000, then i_ex 0x5000 arrives -> output switches to 0x5000/EX with both flushes, o_cnt_override=1. A later i_if 0x6000 is dropped.
5. In HOLD, nreset pulsed low mid-cycle -> outputs 0 immediately. After release, IDLE with no valid until a new request.
6. Preload counter to max via 2^CNT_WIDTH accepts (CNT_WIDTH=4) -> saturates at 15. i_cnt_clear together with an accept -> 0. enable=0 with a valid input -> o_redirect_valid=0 and no counter change.
